// File: rtl/jk_sync_counter_pkg.sv
// jk_sync_counter_pkg: shared definitions for the JK-based synchronous counter.
//   jk_code_t  - per-cell {J,K} drive code (hold / reset / set / toggle)
//   JK_J_BIT   - bit position of J within a jk_code_t
//   JK_K_BIT   - bit position of K within a jk_code_t
// Optional build macro used by the counter: JK_SYNC_COUNTER_SATURATE_EN.
package jk_sync_counter_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_code_t;

  localparam int unsigned JK_J_BIT = 1;
  localparam int unsigned JK_K_BIT = 0;

endpackage

// File: rtl/jk_sync_counter_jk_ff.sv
// jk_ff: rising-edge JK flip-flop cell with synchronous active-high reset.
//   clk - clock, state changes on the rising edge
//   rst - synchronous reset, forces Q to 0
//   J   - set input
//   K   - reset input
//   Q   - registered cell output
// JK semantics: 00 hold, 01 reset, 10 set, 11 toggle.
module jk_ff
  import jk_sync_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic J,
  input  logic K,
  output logic Q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 1'b0;
    end else begin
      case ({J, K})
        JK_RESET:  r_q <= 1'b0;
        JK_SET:    r_q <= 1'b1;
        JK_TOGGLE: r_q <= ~r_q;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign Q = r_q;

endmodule

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: synchronous modulo-MODULUS up/down counter built from
// WIDTH jk_ff cells. Each cycle this block computes a JK code per bit; the
// cells hold the count.
//   clk  - clock
//   rst  - synchronous active-high reset (Q <= 0)
//   En   - count enable
//   Up   - direction, 1 = up, 0 = down
//   Load - parallel load strobe (clamped to MODULUS-1)
//   D    - parallel load value
//   Q    - current count (registered)
//   TC   - terminal count, En & (Up ? Q==MODULUS-1 : Q==0)
// Edge priority: rst > Load > En > hold.
// Build macro JK_SYNC_COUNTER_SATURATE_EN: when defined the counter holds at
// the range ends instead of wrapping; TC still flags the boundary.
module jk_sync_counter
  import jk_sync_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC
);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_param
    $error("jk_sync_counter: WIDTH/MODULUS out of range");
  end

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_load_val;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_run;
  jk_code_t         w_code [WIDTH];

  assign w_at_max   = (w_q == MAX_Q);
  assign w_at_zero  = (w_q == '0);
  assign w_load_val = ({1'b0, D} >= MOD_EXT) ? MAX_Q : D;

  always_comb begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_code[i] = JK_HOLD;
    end
    w_run = 1'b1;

    if (Load) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        w_code[i] = w_load_val[i] ? JK_SET : JK_RESET;
      end
    end else if (En) begin
      if (Up && w_at_max) begin
`ifdef JK_SYNC_COUNTER_SATURATE_EN
        // Saturate: every cell keeps JK_HOLD.
`else
        for (int unsigned i = 0; i < WIDTH; i++) begin
          w_code[i] = w_q[i] ? JK_RESET : JK_HOLD;
        end
`endif
      end else if (!Up && w_at_zero) begin
`ifdef JK_SYNC_COUNTER_SATURATE_EN
        // Saturate: every cell keeps JK_HOLD.
`else
        for (int unsigned i = 0; i < WIDTH; i++) begin
          w_code[i] = MAX_Q[i] ? JK_SET : JK_RESET;
        end
`endif
      end else begin
        // Ripple term: bit i toggles while all lower bits are 1 (up) / 0 (down).
        for (int unsigned i = 0; i < WIDTH; i++) begin
          w_code[i] = w_run ? JK_TOGGLE : JK_HOLD;
          w_run     = w_run & (Up ? w_q[i] : ~w_q[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    logic [1:0] w_jk;
    assign w_jk = w_code[g];

    jk_ff u_ff (
      .clk (clk),
      .rst (rst),
      .J   (w_jk[JK_J_BIT]),
      .K   (w_jk[JK_K_BIT]),
      .Q   (w_q[g])
    );
  end

  assign Q  = w_q;
  assign TC = En & (Up ? w_at_max : w_at_zero);

endmodule

// File: tb/tb_jk_sync_counter.sv
module tb_jk_sync_counter;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;
`ifdef JK_SYNC_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, En, Up, Load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             TC;

  int total = 0;
  int bad   = 0;
  int m_q   = -1;   // reference count; -1 until the first reset

  jk_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
    .clk  (clk),
    .rst  (rst),
    .En   (En),
    .Up   (Up),
    .Load (Load),
    .D    (D),
    .Q    (Q),
    .TC   (TC)
  );

  always #5 clk = ~clk;

  // Reference behaviour written as range arithmetic.
  function automatic int model_next(int q, bit r, bit l, int d, bit e, bit u);
    if (r) return 0;
    if (l) return (d >= MODULUS) ? MODULUS - 1 : d;
    if (!e) return q;
    if (u) begin
      if (SAT && q == MODULUS - 1) return q;
      return (q + 1) % MODULUS;
    end
    if (SAT && q == 0) return 0;
    return (q + MODULUS - 1) % MODULUS;
  endfunction

  function automatic bit model_tc(int q, bit e, bit u);
    return e && (u ? (q == MODULUS - 1) : (q == 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive inputs, check TC combinationally, clock once, check Q and model.
  task automatic step(input bit r, input bit l, input int d, input bit e, input bit u,
                      input string tag);
    rst  = r;
    Load = l;
    D    = WIDTH'(d);
    En   = e;
    Up   = u;
    #1;
    if (m_q >= 0) chk({tag, ".tc"}, 32'(TC), 32'(model_tc(m_q, e, u)));
    @(posedge clk);
    m_q = model_next(m_q, r, l, d, e, u);
    #1;
    chk({tag, ".q"}, 32'(Q), 32'(m_q));
  endtask

  initial begin
    rst = 1'b0; En = 1'b0; Up = 1'b0; Load = 1'b0; D = '0;

    // Reset for two edges with counting requested.
    step(1, 0, 0, 1, 1, "rst0");
    step(1, 0, 0, 1, 1, "rst1");
    chk("rst.q_zero", 32'(Q), 32'd0);
    chk("rst.tc_zero", 32'(TC), 32'd0);

    // Count up nine times to the terminal value.
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 1, "up");
    chk("up9.q", 32'(Q), 32'd9);
    chk("up9.tc", 32'(TC), 32'd1);

    // Boundary going up: wrap (or hold when saturating).
    step(0, 0, 0, 1, 1, "upwrap");
    chk("upwrap.q", 32'(Q), SAT ? 32'd9 : 32'd0);

    // Boundary going down from 0.
    step(0, 1, 0, 1, 0, "ld0");
    step(0, 0, 0, 1, 0, "dnwrap");
    chk("dnwrap.q", 32'(Q), SAT ? 32'd0 : 32'd9);

    // Load wins over count; out-of-range load clamps.
    step(0, 1, 6, 1, 1, "ld6");
    chk("ld6.q", 32'(Q), 32'd6);
    step(0, 1, 13, 1, 0, "ld13");
    chk("ld13.q", 32'(Q), 32'd9);
    step(0, 1, 15, 0, 1, "ld15");

    // Hold with En=0 while Up and D wiggle.
    step(0, 1, 5, 0, 0, "ld5");
    for (int i = 0; i < 5; i++) step(0, 0, i * 3, 0, i[0], "hold");
    chk("hold.q", 32'(Q), 32'd5);
    chk("hold.tc", 32'(TC), 32'd0);

    // Mid-count reset, then count down.
    step(0, 1, 7, 0, 1, "ld7");
    step(1, 0, 0, 1, 1, "midrst");
    chk("midrst.q", 32'(Q), 32'd0);
    step(0, 0, 0, 1, 0, "dn1");
    step(0, 0, 0, 1, 0, "dn2");
    step(0, 0, 0, 1, 0, "dn3");
    if (!SAT) chk("dn3.q", 32'(Q), 32'd7);

    // Direction reversal with no extra latency.
    step(0, 1, 4, 0, 0, "ld4");
    step(0, 0, 0, 1, 1, "rev_up");
    step(0, 0, 0, 1, 0, "rev_dn");
    chk("rev.q", 32'(Q), 32'd4);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 24) == 0,
           $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
